ahb_mem_slave: RTL and testbench

//  AHB responder: a word-organised memory slave that answers transfers issued by the AHB master on the
//  ahb_intf signal set. Sits at the slave end of the bus; in single-slave benches hsel is tied 1.

---
 rtl/ahb_mem_slave.sv | 164 ++++++++++++++++
 tb/tb_ahb_mem_slave.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_mem_slave.sv
// Word-organised AHB memory slave with programmable wait states, two-cycle ERROR
// response and a single-reservation exclusive monitor.
module ahb_mem_slave #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MEM_DEPTH   = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hrst,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [2:0]            hburst,
  input  logic [6:0]            hprot,
  input  logic [2:0]            hsize,
  input  logic                  hnonsec,
  input  logic                  hexcl,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [DATA_WIDTH-1:0] hwdata,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hreadyout,
  output logic [1:0]            hresp,
  output logic                  hexokay
);

  localparam int WORD_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH + 1)'(4 * MEM_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LAST,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t              state, state_d;
  logic [3:0]          cnt, cnt_d;
  logic [WORD_W-1:0]   dp_word;
  logic                dp_write;
  logic [1:0]          dp_size;
  logic [1:0]          dp_lane;
  logic                dp_excl;
  logic                resv_valid;
  logic [WORD_W-1:0]   resv_word;
  logic                resv_hit;
  logic                commit;
  logic [3:0]          be;
  logic [ADDR_WIDTH:0] offset;
  logic                ready_phase;
  logic                accept;
  logic                xfer_err;
  logic                unused_ok;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  assign unused_ok = ^{hburst, hprot, hnonsec, htrans[0]};

  // Addresses below BASE_ADDR wrap to a huge offset, so one compare covers both bounds.
  assign offset = {1'b0, haddr} - {1'b0, BASE_ADDR};

  // Bus handshake: an address phase is taken on a posedge where hsel && htrans[1] && hreadyout;
  // its data phase ends on the first later posedge with hreadyout=1.
  always_comb begin
    ready_phase = (state == ST_IDLE) || (state == ST_LAST) || (state == ST_ERR2);
    accept      = hsel && htrans[1] && ready_phase;
    xfer_err    = (offset >= SPAN) || (hsize > 3'd2) ||
                  ((hsize == 3'd1) && haddr[0]) ||
                  ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    hreadyout = 1'b1;
    hresp     = 2'b00;
    case (state)
      ST_WAIT: begin
        hreadyout = 1'b0;
        cnt_d     = cnt - 4'd1;
        if (cnt <= 4'd1) state_d = ST_LAST;
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 2'b01;
        state_d   = ST_ERR2;
      end
      ST_ERR2: hresp = 2'b01;
      default: ;
    endcase
    if (ready_phase) begin
      if (accept && xfer_err) begin
        state_d = ST_ERR1;
      end else if (accept) begin
        if (WAIT_STATES == 0) begin
          state_d = ST_LAST;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = 4'(WAIT_STATES);
        end
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_comb begin
    be = 4'b0000;
    case (dp_size)
      2'd0:    be = 4'b0001 << dp_lane;
      2'd1:    be = dp_lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  assign resv_hit = resv_valid && (resv_word == dp_word);
  // An exclusive write only lands while its reservation is still held.
  assign commit   = (state == ST_LAST) && dp_write && (!dp_excl || resv_hit);
  assign hexokay  = (state == ST_LAST) && dp_excl && (!dp_write || resv_hit);
  assign hrdata   = ((state == ST_WAIT) || (state == ST_LAST)) ? mem[dp_word] : '0;

  always_ff @(posedge hclk) begin
    if (hrst) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      dp_word    <= '0;
      dp_write   <= 1'b0;
      dp_size    <= 2'd0;
      dp_lane    <= 2'd0;
      dp_excl    <= 1'b0;
      resv_valid <= 1'b0;
      resv_word  <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (accept && !xfer_err) begin
        dp_word  <= offset[WORD_W+1:2];
        dp_write <= hwrite;
        dp_size  <= hsize[1:0];
        dp_lane  <= haddr[1:0];
        dp_excl  <= hexcl;
      end
      if (state == ST_LAST) begin
        if (commit && resv_hit) begin
          resv_valid <= 1'b0;
        end else if (!dp_write && dp_excl) begin
          resv_valid <= 1'b1;
          resv_word  <= dp_word;
        end
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (!hrst && commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[dp_word][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Bench for ahb_mem_slave: two instances (0 and 2 wait states) behind a shared bus,
// randomized traffic checked by a queue scoreboard fed from a behavioural memory model.
module tb_ahb_mem_slave;

  localparam int DEPTH = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        hsel_bus;
  logic [31:0] haddr;
  logic [2:0]  hburst;
  logic [6:0]  hprot;
  logic [2:0]  hsize;
  logic        hnonsec;
  logic        hexcl;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] hwdata;
  int          sel;

  logic        hsel0, hsel1;
  logic [31:0] rdata0, rdata1;
  logic        ready0, ready1, exok0, exok1;
  logic [1:0]  resp0, resp1;
  logic [31:0] hrdata;
  logic        hready, hexokay;
  logic [1:0]  hresp;

  assign hsel0   = hsel_bus && (sel == 0);
  assign hsel1   = hsel_bus && (sel == 1);
  assign hrdata  = (sel == 1) ? rdata1 : rdata0;
  assign hready  = (sel == 1) ? ready1 : ready0;
  assign hresp   = (sel == 1) ? resp1  : resp0;
  assign hexokay = (sel == 1) ? exok1  : exok0;

  ahb_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH),
                  .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
    .hclk(clk), .hrst(rst), .hsel(hsel0), .haddr(haddr), .hburst(hburst), .hprot(hprot),
    .hsize(hsize), .hnonsec(hnonsec), .hexcl(hexcl), .htrans(htrans), .hwrite(hwrite),
    .hwdata(hwdata), .hrdata(rdata0), .hreadyout(ready0), .hresp(resp0), .hexokay(exok0)
  );

  ahb_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH),
                  .BASE_ADDR(32'h400), .WAIT_STATES(2)) dut1 (
    .hclk(clk), .hrst(rst), .hsel(hsel1), .haddr(haddr), .hburst(hburst), .hprot(hprot),
    .hsize(hsize), .hnonsec(hnonsec), .hexcl(hexcl), .htrans(htrans), .hwrite(hwrite),
    .hwdata(hwdata), .hrdata(rdata1), .hreadyout(ready1), .hresp(resp1), .hexokay(exok1)
  );

  int total = 0;
  int bad   = 0;

  // Entry layout: [38] error, [37] write, [36] exokay, [35:32] low cycles, [31:0] read data.
  logic [38:0] exp_q[$];

  logic [31:0] ref_mem [2][DEPTH];
  logic        rv [2];
  int          ra [2];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [31:0] base_of(input int d);
    return (d == 1) ? 32'h400 : 32'h0;
  endfunction

  task automatic model_push(input int d, input logic wr, input logic [31:0] addr,
                            input logic [2:0] size, input logic [31:0] wdata, input logic ex);
    logic        err, exok;
    logic [31:0] rd, mask, base;
    logic [3:0]  waits;
    int          w;
    base  = base_of(d);
    err   = (addr < base) || (addr >= base + 4 * DEPTH) || (size > 3'd2) ||
            (size == 3'd1 && addr % 2 != 0) || (size == 3'd2 && addr % 4 != 0);
    exok  = 1'b0;
    rd    = 32'h0;
    waits = err ? 4'd1 : ((d == 1) ? 4'd2 : 4'd0);
    if (!err) begin
      w = int'((addr - base) / 4);
      if (wr) begin
        if (!ex || (rv[d] && ra[d] == w)) begin
          if (size == 3'd0)      mask = 32'hFF << (8 * (addr % 4));
          else if (size == 3'd1) mask = 32'hFFFF << (8 * (addr % 4));
          else                   mask = 32'hFFFF_FFFF;
          ref_mem[d][w] = (ref_mem[d][w] & ~mask) | (wdata & mask);
          if (rv[d] && ra[d] == w) rv[d] = 1'b0;
          exok = ex;
        end
      end else begin
        rd = ref_mem[d][w];
        if (ex) begin
          rv[d] = 1'b1;
          ra[d] = w;
          exok  = 1'b1;
        end
      end
    end
    exp_q.push_back({err, wr, exok, waits, rd});
  endtask

  // Wait for the posedge that takes the currently driven address phase.
  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!hready && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (!hready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout actual=0 required=1 at %0t", $time);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input logic [1:0] tr, input logic s);
    hsel_bus = s;
    htrans   = tr;
    hexcl    = 1'b0;
    wait_ready();
  endtask

  task automatic flush();
    idle_cycle(2'b00, 1'b0);
  endtask

  task automatic issue(input int d, input logic wr, input logic [31:0] addr,
                       input logic [2:0] size, input logic [31:0] wdata, input logic ex);
    if (d != sel) begin
      flush();
      sel = d;
    end
    hsel_bus = 1'b1;
    htrans   = 2'b10;
    hwrite   = wr;
    haddr    = addr;
    hsize    = size;
    hexcl    = ex;
    hburst   = 3'($urandom);
    hprot    = 7'($urandom);
    hnonsec  = 1'($urandom);
    wait_ready();
    hwdata = wdata;
    model_push(d, wr, addr, size, wdata, ex);
  endtask

  initial begin : monitor
    logic [38:0] e;
    int          low;
    logic        in_dp;
    in_dp = 1'b0;
    low   = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_dp = 1'b0;
        low   = 0;
      end else begin
        if (in_dp) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL no_expect actual=data_phase required=none at %0t", $time);
            in_dp = 1'b0;
          end else if (!hready) begin
            e = exp_q[0];
            low++;
            check("resp_wait", {30'd0, hresp}, e[38] ? 32'd1 : 32'd0);
            check("exok_wait", {31'd0, hexokay}, 32'd0);
            if (low > 20) begin
              check("wait_timeout", low, e[35:32]);
              void'(exp_q.pop_front());
              in_dp = 1'b0;
              low   = 0;
            end
          end else begin
            e = exp_q.pop_front();
            check("waits", low, {28'd0, e[35:32]});
            check("resp", {30'd0, hresp}, {31'd0, e[38]});
            check("exokay", {31'd0, hexokay}, {31'd0, e[36]});
            if (!e[37] || e[38]) check("rdata", hrdata, e[38] ? 32'd0 : e[31:0]);
            in_dp = 1'b0;
            low   = 0;
          end
        end else begin
          check("idle_ready", {31'd0, hready}, 32'd1);
          check("idle_resp", {30'd0, hresp}, 32'd0);
          check("idle_rdata", hrdata, 32'd0);
          check("idle_exok", {31'd0, hexokay}, 32'd0);
        end
        if (hsel_bus && htrans[1] && hready) in_dp = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int          d, w, kind;
    logic [2:0]  sz;
    logic [31:0] a;
    rst = 1'b1; hsel_bus = 1'b0; haddr = 32'h0; hburst = 3'd0; hprot = 7'd0; hsize = 3'd0;
    hnonsec = 1'b0; hexcl = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h0; sel = 0;
    rv[0] = 1'b0; rv[1] = 1'b0; ra[0] = 0; ra[1] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready0", {31'd0, ready0}, 32'd1);
    check("rst_resp0", {30'd0, resp0}, 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_exok0", {31'd0, exok0}, 32'd0);
    check("rst_ready1", {31'd0, ready1}, 32'd1);
    check("rst_resp1", {30'd0, resp1}, 32'd0);
    check("rst_rdata1", rdata1, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Give every word a known value in both memories.
    for (int dd = 0; dd < 2; dd++)
      for (int i = 0; i < DEPTH; i++)
        issue(dd, 1'b1, base_of(dd) + 32'(4 * i), 3'd2, $urandom, 1'b0);

    // Zero-wait back-to-back write then read.
    issue(0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 1'b0);
    issue(0, 1'b0, 32'h10, 3'd2, $urandom, 1'b0);
    // Byte lane merge.
    issue(0, 1'b1, 32'h10, 3'd2, 32'h11223344, 1'b0);
    issue(0, 1'b1, 32'h13, 3'd0, 32'hAABBCCDD, 1'b0);
    issue(0, 1'b0, 32'h10, 3'd2, $urandom, 1'b0);
    // Two wait states on a single read.
    issue(1, 1'b0, 32'h400, 3'd2, $urandom, 1'b0);
    flush();
    // Errors: past the end, misaligned half, illegal size; memory left intact.
    issue(1, 1'b0, 32'h500, 3'd2, $urandom, 1'b0);
    issue(1, 1'b1, 32'h401, 3'd1, 32'hFFFF_FFFF, 1'b0);
    issue(1, 1'b1, 32'h3FC, 3'd2, 32'hFFFF_FFFF, 1'b0);
    issue(1, 1'b0, 32'h400, 3'd2, $urandom, 1'b0);
    issue(0, 1'b1, 32'h100, 3'd2, 32'hFFFF_FFFF, 1'b0);
    issue(0, 1'b1, 32'h01, 3'd1, 32'hFFFF_FFFF, 1'b0);
    issue(0, 1'b1, 32'h04, 3'd3, 32'hFFFF_FFFF, 1'b0);
    issue(0, 1'b0, 32'h00, 3'd2, $urandom, 1'b0);
    // Exclusive pair, then a stale retry.
    issue(0, 1'b0, 32'h20, 3'd2, $urandom, 1'b1);
    issue(0, 1'b1, 32'h20, 3'd2, 32'h5, 1'b1);
    issue(0, 1'b1, 32'h20, 3'd2, 32'h6, 1'b1);
    issue(0, 1'b0, 32'h20, 3'd2, $urandom, 1'b0);
    // A plain write to the reserved word kills the reservation.
    issue(0, 1'b0, 32'h24, 3'd2, $urandom, 1'b1);
    issue(0, 1'b1, 32'h24, 3'd2, 32'h77, 1'b0);
    issue(0, 1'b1, 32'h24, 3'd2, 32'h88, 1'b1);
    // An error in between leaves the reservation alone.
    issue(0, 1'b0, 32'h28, 3'd2, $urandom, 1'b1);
    issue(0, 1'b0, 32'h200, 3'd2, $urandom, 1'b0);
    issue(0, 1'b1, 32'h28, 3'd2, 32'h99, 1'b1);
    issue(0, 1'b0, 32'h28, 3'd2, $urandom, 1'b0);

    // Reset in the wait phase of a write: the write is dropped.
    issue(1, 1'b0, 32'h404, 3'd2, $urandom, 1'b0);
    flush();
    hsel_bus = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h440; hsize = 3'd2; hexcl = 1'b0;
    wait_ready();
    hwdata   = 32'hCAFE_F00D;
    rst      = 1'b1;
    htrans   = 2'b00;
    hsel_bus = 1'b0;
    @(negedge clk);
    check("rst_mid_wait", {31'd0, hready}, 32'd0);
    @(negedge clk);
    check("rst_after_ready", {31'd0, hready}, 32'd1);
    check("rst_after_resp", {30'd0, hresp}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    rv[0] = 1'b0;
    rv[1] = 1'b0;
    issue(1, 1'b0, 32'h440, 3'd2, $urandom, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      d    = $urandom_range(0, 1);
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        if ($urandom_range(0, 2) == 2) idle_cycle(2'b10, 1'b0);
        else idle_cycle(2'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        sz = ($urandom_range(0, 15) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
        w  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, DEPTH - 1);
        a  = base_of(d) + 32'(4 * w);
        if (sz == 3'd0) a = a + 32'($urandom_range(0, 3));
        if (sz == 3'd1) a = a + 32'(2 * $urandom_range(0, 1));
        if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
        if ($urandom_range(0, 19) == 0) a = base_of(d) + 32'(4 * DEPTH + 4 * $urandom_range(0, 3));
        if (d == 1 && $urandom_range(0, 29) == 0) a = 32'h3FC;
        issue(d, 1'($urandom_range(0, 1)), a, sz, $urandom, $urandom_range(0, 3) == 0);
      end
    end

    flush();
    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
